// File: rtl/uncache_axi_bridge_if.sv
// ============================================================================
// Interfaces: AXI_UNCACHE_Interface (uncached request side) and
//             uncache_axi_bridge_if (single-beat AXI4 memory port)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface AXI_UNCACHE_Interface;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [1:0]  ld_size;
   logic        rd_rdy;
   logic        ret_valid;
   logic [31:0] ret_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_wstrb;
   logic        wr_rdy;
   logic        wr_valid;

   modport master (
      output rd_req, rd_addr, ld_size, wr_req, wr_addr, wr_data, wr_wstrb,
      input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
   );
   modport slave (
      input  rd_req, rd_addr, ld_size, wr_req, wr_addr, wr_data, wr_wstrb,
      output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
   );
endinterface

interface uncache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
             awid, awaddr, awlen, awsize, awburst, awvalid,
             wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
             awready, wready, bid, bresp, bvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
             awid, awaddr, awlen, awsize, awburst, awvalid,
             wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rresp, rlast, rvalid,
             awready, wready, bid, bresp, bvalid
   );
endinterface

`default_nettype wire

// File: rtl/uncache_axi_bridge.sv
// ============================================================================
// Module : uncache_axi_bridge
// Uncached single-word read/write requests to single-beat AXI4 transactions.
// Option : UNCACHE_POSTED_WRITE_EN - complete writes after AW/W, before B.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uncache_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic                 clk,
   input  logic                 rst,
   AXI_UNCACHE_Interface.slave  s_unc,
   uncache_axi_bridge_if.master m_axi
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_AR  = 3'd1,
      S_RD_R   = 3'd2,
      S_WR_REQ = 3'd3,
      S_WR_B   = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
   logic        r_aw_done, r_w_done;
   logic        r_ret_valid, r_wr_valid;
   logic [31:0] r_addr, r_wdata, r_ret_data;
   logic [3:0]  r_wstrb;
   logic [2:0]  r_size;

   logic        w_idle_rdy, w_aw_fin, w_w_fin;
   logic        w_unused_ok;

   function automatic logic [2:0] f_awsize(input logic [3:0] strb);
      case (strb)
         4'b1111:                             f_awsize = 3'd2;
         4'b0011, 4'b1100:                    f_awsize = 3'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000:  f_awsize = 3'd0;
         default:                             f_awsize = 3'd2;
      endcase
   endfunction

   // No acceptance while a completion pulse is on the wire; writes win over reads.
   assign w_idle_rdy = (r_state == S_IDLE) & ~r_ret_valid & ~r_wr_valid;
   assign w_aw_fin   = r_aw_done | (r_awvalid & m_axi.awready);
   assign w_w_fin    = r_w_done  | (r_wvalid  & m_axi.wready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_ret_valid <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_ret_data  <= 32'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_wstrb     <= 4'd0;
         r_size      <= 3'd0;
      end else begin
         r_ret_valid <= 1'b0;
         r_wr_valid  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_idle_rdy && s_unc.wr_req) begin
                  r_addr    <= s_unc.wr_addr;
                  r_wdata   <= s_unc.wr_data;
                  r_wstrb   <= s_unc.wr_wstrb;
                  r_size    <= f_awsize(s_unc.wr_wstrb);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_state   <= S_WR_REQ;
               end else if (w_idle_rdy && s_unc.rd_req) begin
                  r_addr    <= s_unc.rd_addr;
                  r_size    <= {1'b0, s_unc.ld_size};
                  r_arvalid <= 1'b1;
                  r_state   <= S_RD_AR;
               end
            end
            S_RD_AR: begin
               if (r_arvalid && m_axi.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_R;
               end
            end
            S_RD_R: begin
               if (m_axi.rvalid) begin
                  r_rready    <= 1'b0;
                  r_ret_data  <= m_axi.rdata;
                  r_ret_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_WR_REQ: begin
               if (r_awvalid && m_axi.awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid && m_axi.wready) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= S_WR_B;
`ifdef UNCACHE_POSTED_WRITE_EN
                  r_wr_valid <= 1'b1;
`endif
               end
            end
            S_WR_B: begin
               if (m_axi.bvalid) begin
                  r_bready <= 1'b0;
                  r_state  <= S_IDLE;
`ifdef UNCACHE_POSTED_WRITE_EN
`else
                  r_wr_valid <= 1'b1;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_unc.rd_rdy    = w_idle_rdy & ~s_unc.wr_req;
   assign s_unc.wr_rdy    = w_idle_rdy;
   assign s_unc.ret_valid = r_ret_valid;
   assign s_unc.ret_data  = r_ret_data;
   assign s_unc.wr_valid  = r_wr_valid;

   assign m_axi.arid    = AXI_ID;
   assign m_axi.araddr  = r_addr;
   assign m_axi.arlen   = 8'd0;
   assign m_axi.arsize  = r_size;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.rready  = r_rready;
   assign m_axi.awid    = AXI_ID;
   assign m_axi.awaddr  = r_addr;
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = r_size;
   assign m_axi.awburst = 2'b01;
   assign m_axi.awvalid = r_awvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.wlast   = 1'b1;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.bready  = r_bready;

   // Response IDs and status are deliberately ignored.
   assign w_unused_ok = &{1'b0, m_axi.rid, m_axi.rresp, m_axi.rlast, m_axi.bid, m_axi.bresp};

endmodule

`default_nettype wire

// File: tb/tb_uncache_axi_bridge.sv
// ============================================================================
// Module : tb_uncache_axi_bridge
// Scoreboard bench for uncache_axi_bridge with a delay-configurable AXI slave.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uncache_axi_bridge;

`ifdef UNCACHE_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   AXI_UNCACHE_Interface u ();
   uncache_axi_bridge_if m ();

   uncache_axi_bridge #(.AXI_ID(4'd1)) dut (
      .clk   (clk),
      .rst   (rst),
      .s_unc (u.slave),
      .m_axi (m.master)
   );

   typedef struct { logic [31:0] a; logic [2:0] sz; int held; } addr_t;
   typedef struct { logic [31:0] d; logic [3:0] s; int held; } wdat_t;
   typedef struct { logic [31:0] d; int lat; } ret_t;

   addr_t exp_ar[$];
   addr_t exp_aw[$];
   wdat_t exp_w[$];
   ret_t  exp_ret[$];
   int    exp_wr[$];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int rd_acc = 0, wr_acc = 0, b_cyc = -10;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [31:0] rdata_v = 32'd0;

   bit ar_seen, r_seen, aw_seen, w_seen, b_seen, rst_seen;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // AXI slave model: drives just after each rising edge
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit r_pend = 0, b_pend = 0, awd = 0, wd = 0;
   always @(posedge clk) begin
      #1;
      if (rst_seen) begin
         r_pend = 0; b_pend = 0; awd = 0; wd = 0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         m.arready = 0; m.rvalid = 0; m.awready = 0; m.wready = 0; m.bvalid = 0;
      end else begin
         if (ar_seen) begin r_pend = 1; r_cnt = 0; end
         if (r_seen) r_pend = 0;
         if (aw_seen) awd = 1;
         if (w_seen) wd = 1;
         if (awd && wd) begin b_pend = 1; b_cnt = 0; awd = 0; wd = 0; end
         if (b_seen) b_pend = 0;
         m.arready = m.arvalid && (ar_cnt == ar_dly);
         ar_cnt    = (m.arvalid && !m.arready) ? ar_cnt + 1 : 0;
         m.awready = m.awvalid && (aw_cnt == aw_dly);
         aw_cnt    = (m.awvalid && !m.awready) ? aw_cnt + 1 : 0;
         m.wready  = m.wvalid && (w_cnt == w_dly);
         w_cnt     = (m.wvalid && !m.wready) ? w_cnt + 1 : 0;
         m.rvalid  = r_pend && (r_cnt == r_dly);
         if (r_pend && !m.rvalid) r_cnt++;
         m.bvalid  = b_pend && (b_cnt == b_dly);
         if (b_pend && !m.bvalid) b_cnt++;
         m.rdata   = rdata_v;
      end
   end

   // Monitor: samples on the falling edge and pops the scoreboard
   int ar_run = 0, aw_run = 0, w_run = 0;
   bit prev_ret = 0, prev_wr = 0;
   always @(negedge clk) begin
      addr_t ea;
      wdat_t ew;
      ret_t  er;
      int    el;
      rst_seen = rst;
      ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
      if (!rst) begin
         ar_run = m.arvalid ? ar_run + 1 : 0;
         aw_run = m.awvalid ? aw_run + 1 : 0;
         w_run  = m.wvalid  ? w_run + 1  : 0;
         if (u.rd_req && u.wr_req && u.wr_rdy) chk("rd_rdy_vs_wr", u.rd_rdy, 0);
         if (u.rd_req && u.rd_rdy) rd_acc = cyc;
         if (u.wr_req && u.wr_rdy) wr_acc = cyc;
         if (m.arvalid && m.arready) begin
            ar_seen = 1;
            if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
               ea = exp_ar.pop_front();
               chk("araddr", m.araddr, ea.a);
               chk("arsize", m.arsize, ea.sz);
               chk("arvalid_cycles", ar_run, ea.held);
               chk("ar_const", {m.arlen, m.arburst, m.arid}, {8'd0, 2'b01, 4'd1});
            end
         end
         if (m.awvalid && m.awready) begin
            aw_seen = 1;
            if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               ea = exp_aw.pop_front();
               chk("awaddr", m.awaddr, ea.a);
               chk("awsize", m.awsize, ea.sz);
               chk("awvalid_cycles", aw_run, ea.held);
               chk("aw_const", {m.awlen, m.awburst, m.awid}, {8'd0, 2'b01, 4'd1});
            end
         end
         if (m.wvalid && m.wready) begin
            w_seen = 1;
            if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               ew = exp_w.pop_front();
               chk("wdata", m.wdata, ew.d);
               chk("wstrb", m.wstrb, ew.s);
               chk("wvalid_cycles", w_run, ew.held);
               chk("wlast", m.wlast, 1);
            end
         end
         r_seen = m.rvalid && m.rready;
         if (m.bvalid && m.bready) begin b_seen = 1; b_cyc = cyc; end
         if (u.ret_valid) begin
            chk("ret_pulse_width", prev_ret, 0);
            chk("rdy_in_ret_pulse", {u.rd_rdy, u.wr_rdy}, 0);
            if (exp_ret.size() == 0) chk("ret_unexpected", 1, 0);
            else begin
               er = exp_ret.pop_front();
               chk("ret_data", u.ret_data, er.d);
               if (er.lat >= 0) chk("ret_latency", cyc - rd_acc, er.lat);
            end
         end
         if (u.wr_valid) begin
            chk("wr_pulse_width", prev_wr, 0);
            chk("rdy_in_wr_pulse", {u.rd_rdy, u.wr_rdy}, 0);
`ifndef UNCACHE_POSTED_WRITE_EN
            chk("wr_after_b", cyc - b_cyc, 1);
`endif
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               el = exp_wr.pop_front();
               if (el >= 0) chk("wr_latency", cyc - wr_acc, el);
            end
         end
      end
      prev_ret = u.ret_valid;
      prev_wr  = u.wr_valid;
   end

   task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input int lat, input bit wait_done);
      int n;
      exp_ar.push_back('{a, {1'b0, sz}, 1});
      exp_ret.push_back('{d, lat});
      rdata_v = d;
      @(posedge clk); #1;
      u.rd_req = 1; u.rd_addr = a; u.ld_size = sz;
      n = 0;
      do begin @(negedge clk); n++; end while (u.rd_rdy !== 1'b1 && n < 100);
      chk("rd_accept", u.rd_rdy, 1);
      @(posedge clk); #1;
      u.rd_req = 0;
      if (wait_done) begin
         n = 0;
         do begin @(negedge clk); n++; end while (u.ret_valid !== 1'b1 && n < 100);
         chk("rd_done", u.ret_valid, 1);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] sz, input int aw_held, input int lat,
                           input bit wait_done);
      int n;
      exp_aw.push_back('{a, sz, aw_held});
      exp_w.push_back('{d, s, 1});
      exp_wr.push_back(lat);
      @(posedge clk); #1;
      u.wr_req = 1; u.wr_addr = a; u.wr_data = d; u.wr_wstrb = s;
      n = 0;
      do begin @(negedge clk); n++; end while (u.wr_rdy !== 1'b1 && n < 100);
      chk("wr_accept", u.wr_rdy, 1);
      @(posedge clk); #1;
      u.wr_req = 0;
      if (wait_done) begin
         n = 0;
         do begin @(negedge clk); n++; end while (u.wr_valid !== 1'b1 && n < 100);
         chk("wr_done", u.wr_valid, 1);
      end
   endtask

   initial begin
      int bad;
      int wa;
      u.rd_req = 0; u.rd_addr = 0; u.ld_size = 0;
      u.wr_req = 0; u.wr_addr = 0; u.wr_data = 0; u.wr_wstrb = 0;
      m.arready = 0; m.rvalid = 0; m.awready = 0; m.wready = 0; m.bvalid = 0;
      m.rdata = 0; m.rresp = 2'b10; m.rid = 4'd1; m.rlast = 1; m.bid = 4'd1; m.bresp = 2'b10;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_rdy", {u.rd_rdy, u.wr_rdy}, 2'b11);
      chk("rst_axi_valids", {m.arvalid, m.rready, m.awvalid, m.wvalid, m.bready}, 0);
      chk("rst_pulses", {u.ret_valid, u.wr_valid}, 0);
      chk("rst_ret_data", u.ret_data, 0);

      // Zero-wait reads and writes
      do_read(32'h1FD0_0000, 2'd2, 32'hDEAD_BEEF, 3, 1);
      do_read(32'h1FD0_0002, 2'd1, 32'h1234_5678, 3, 1);
      do_write(32'h1FD0_0010, 32'hCAFE_F00D, 4'b1111, 3'd2, 1, POSTED ? 2 : 3, 1);
      do_write(32'h1FD0_0022, 32'h5A5A_0000, 4'b1100, 3'd1, 1, POSTED ? 2 : 3, 1);
      do_write(32'h1FD0_0030, 32'h00FF_00FF, 4'b0101, 3'd2, 1, POSTED ? 2 : 3, 1);

      // Byte write with AWREADY delayed three cycles
      aw_dly = 3;
      do_write(32'hBFAF_8001, 32'h0000_AB00, 4'b0010, 3'd0, 4, POSTED ? 5 : 6, 1);
      aw_dly = 0;
      repeat (2) @(posedge clk);

      // Simultaneous read and write: write first, read after completion
      fork
         do_write(32'h1FD0_0040, 32'h1111_2222, 4'b1111, 3'd2, 1, POSTED ? 2 : 3, 1);
         do_read(32'h1FD0_0044, 2'd2, 32'h3333_4444, 3, 1);
      join
      chk("simul_rd_after_wr", rd_acc - wr_acc, POSTED ? 3 : 4);

      // RVALID withheld ten cycles
      r_dly = 10;
      do_read(32'h1FD0_0050, 2'd2, 32'hA5A5_5A5A, 13, 0);
      @(posedge clk);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (u.rd_rdy !== 0 || u.wr_rdy !== 0 || m.rready !== 1 || u.ret_valid !== 0) bad++;
      end
      chk("rwait_hold", bad, 0);
      bad = 0;
      while (u.ret_valid !== 1'b1 && bad < 20) begin @(negedge clk); bad++; end
      chk("rwait_done", u.ret_valid, 1);

      // Reset pulsed while waiting for R
      r_dly = 30;
      do_read(32'h1FD0_0060, 2'd2, 32'h0BAD_0BAD, -1, 0);
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("rst_mid_rready", m.rready, 0);
      chk("rst_mid_rdy", {u.rd_rdy, u.wr_rdy}, 2'b11);
      chk("rst_mid_ret", u.ret_valid, 0);
      void'(exp_ret.pop_back());
      r_dly = 0;
      repeat (3) @(posedge clk);
      do_read(32'h1FD0_0070, 2'd0, 32'h7700_0077, 3, 1);

      // B delayed five cycles, read issued three cycles after the write
      b_dly = 5;
      do_write(32'h1FD0_0080, 32'h8888_8888, 4'b1111, 3'd2, 1, POSTED ? 2 : 8, 0);
      wa = wr_acc;
      @(posedge clk);
      do_read(32'h1FD0_0084, 2'd2, 32'h9999_0000, 3, 1);
      chk("bdelay_rd_hold", rd_acc - wa, POSTED ? 8 : 9);
      b_dly = 0;

      repeat (4) @(posedge clk);
      chk("q_ret_empty", exp_ret.size(), 0);
      chk("q_wr_empty", exp_wr.size(), 0);
      chk("q_axi_empty", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/uncache_axi_bridge.md
# uncache_axi_bridge

Slave-side responder for the uncached access interface (`AXI_UNCACHE_Interface`, `slave` modport). It accepts single-word uncached read and write requests from the cache/CPU side and executes each as one single-beat AXI4 transaction on the memory port. It returns read data or write completion on the same interface. It sits between the uncached path of the D-side and the AXI crossbar, with one transaction outstanding at a time.

## Interface
- `AXI_ID`, default 4'd1: constant ARID/AWID value.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rd_req`  in  1: read request, qualified by `rd_rdy`.
- `rd_addr`  in  32: physical read address.
- `ld_size`  in  2: read size decoded from `loadType`; 0 = byte, 1 = half, 2 = word.
- `rd_rdy`  out  1: bridge can accept a read.
- `ret_valid`  out  1: one-cycle pulse; `ret_data` valid.
- `ret_data`  out  32: raw RDATA word, not shifted or extended.
- `wr_req`  in  1: write request, qualified by `wr_rdy`.
- `wr_addr`  in  32: physical write address.
- `wr_data`  in  32: write data, lane-aligned.
- `wr_wstrb`  in  4: byte enables.
- `wr_rdy`  out  1: bridge can accept a write.
- `wr_valid`  out  1: one-cycle pulse; write completed.
- AXI AR: `arid`[4] `araddr`[32] `arlen`[8]=0 `arsize`[3] `arburst`[2]=01 `arvalid` out; `arready` in.
- AXI R: `rid`[4] `rdata`[32] `rresp`[2] `rlast` `rvalid` in; `rready` out.
- AXI AW: `awid` `awaddr` `awlen`=0 `awsize` `awburst`=01 `awvalid` out; `awready` in.
- AXI W: `wdata`[32] `wstrb`[4] `wlast`=1 `wvalid` out; `wready` in.
- AXI B: `bid` `bresp` `bvalid` in; `bready` out.

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B.
- IDLE: `rd_rdy` = `wr_rdy` = 1. A request is accepted when req && rdy in the same cycle, and address, data, strobe and size are latched.
- Simultaneous `rd_req` and `wr_req` in IDLE: the write is accepted and the read is not. `rd_rdy` drops combinationally when `wr_req`=1, so the requester holds `rd_req`.
- RD_AR: `arvalid`=1 until `arready`, then RD_R. `arsize` = {0, ld_size}.
- RD_R: `rready`=1. On `rvalid`, latch `rdata` and go to IDLE. The next cycle pulses `ret_valid`=1 for exactly one cycle.
- WR_REQ: `awvalid` and `wvalid` are asserted together and drop independently on their own handshakes, tracked by done flags. When both are done, go to WR_B.
- `awsize` from strobe: 4'b1111 → 2; 0011 or 1100 → 1; one-hot → 0; any other pattern → 2.
- WR_B: `bready`=1. On `bvalid`, go to IDLE and pulse `wr_valid` for one cycle.
- `rresp`, `bresp`, `rid` and `bid` are ignored. Error responses complete normally.
- AXI valids are held stable until handshake; address and data never change while valid.
- `rd_rdy` and `wr_rdy` are 0 in every non-IDLE state and in the cycle a `ret_valid` or `wr_valid` pulse is driven.

## Timing
- Reset values: `rd_rdy`=`wr_rdy`=1, all AXI valid/ready outputs = 0, `ret_valid`=`wr_valid`=0, `ret_data`=0; state IDLE.
- Minimum read latency, with `arready` and `rvalid` immediate: accept at cycle 0, `arvalid` at cycle 1, `rready`/`rvalid` at cycle 2, `ret_valid` at cycle 3.
- Minimum write latency: accept at 0, AW/W at 1, B at 2, `wr_valid` at 3.
- Back-to-back: the next request is accepted in the cycle after the completion pulse.
- `rst` asserted mid-transaction returns to IDLE next edge and drops all valids. The outstanding AXI transaction is abandoned; the interconnect is reset by the same `rst`.

## Configuration
- `UNCACHE_POSTED_WRITE_EN` defined:
  - `wr_valid` pulses in the cycle after AW and W have both handshaked, without waiting for B.
  - The B wait continues in the background.
  - A new write, or a read, is not accepted until B is received; `rd_rdy`/`wr_rdy` stay 0.
- Undefined: `wr_valid` only after the B handshake, as described above.

## Test plan
- Word read, `rd_addr`=0x1FD0_0000, `ld_size`=2, AXI returns 0xDEAD_BEEF with zero wait → `arsize`=2, `arlen`=0, `ret_data`=0xDEAD_BEEF, `ret_valid` high one cycle at cycle 3.
- Byte write, `wr_addr`=0xBFAF_8001, `wr_wstrb`=0010, data 0x0000_AB00, `awready` delayed 3 cycles and `wready` immediate → `awsize`=0, `wvalid` drops after 1 cycle, `awvalid` held 4 cycles, `wr_valid` one cycle after `bvalid`.
- `rd_req` and `wr_req` in the same cycle → the write runs first and `rd_rdy`=0. The read starts after `wr_valid`, and the AR address equals the held `rd_addr`.
- `rvalid` withheld for 10 cycles → `rready` held high, no `ret_valid` early, `rd_rdy`/`wr_rdy` stay 0.
- `rst` pulsed while in RD_R → next cycle: state IDLE, `rready`=0, `rd_rdy`=1, no `ret_valid`.
- With `UNCACHE_POSTED_WRITE_EN` and `bvalid` delayed 5 cycles → `wr_valid` at cycle 2. A read issued at cycle 3 is held off (`rd_rdy`=0) until `bvalid`.
